// File: rtl/decrypter_axi_master_if.sv
// One AXI4-Lite channel: a valid/ready handshake carrying an information word.
interface axi_channel #(
  parameter int width_g = 32
) ();
  logic               valid;
  logic               ready;
  logic [width_g-1:0] information;

  modport source (output valid, output information, input ready);
  modport target (input valid, input information, output ready);
  modport master (output valid, output information, input ready);
  modport slave  (input valid, input information, output ready);
endinterface

// File: rtl/decrypter_axi_master.sv
// AXI4-Lite write initiator for the decrypter target port, with per-state timeout and status counters.
// Optional address cache enabled by defining DEC_AXI_MASTER_ADDR_CACHE_EN.
module decrypter_axi_master #(
  parameter int data_width_g = 32,
  parameter int timeout_g    = 64,
  parameter int cnt_width_g  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [data_width_g-1:0] cmd_addr,
  input  logic [data_width_g-1:0] cmd_data,
  axi_channel.source              waddr_channel,
  axi_channel.source              wdata_channel,
  axi_channel.target              wresp_channel,
  output logic                    rsp_valid,
  output logic [1:0]              rsp_code,
  output logic                    rsp_timeout,
  output logic [cnt_width_g-1:0]  okay_count,
  output logic [cnt_width_g-1:0]  err_count
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  localparam int            TW    = $clog2(timeout_g) + 1;
  localparam logic [TW-1:0] TLAST = TW'(timeout_g - 1);

  state_t                  state_q;
  logic                    cmd_ready_q;
  logic                    awvld_q, wvld_q, brdy_q;
  logic [data_width_g-1:0] awinfo_q, winfo_q, data_q;
  logic                    rsp_valid_q, rsp_timeout_q;
  logic [1:0]              rsp_code_q;
  logic [TW-1:0]           tmo_cnt_q;
  logic [cnt_width_g-1:0]  okay_cnt_q, err_cnt_q;

  logic aw_hs, w_hs, b_hs, expired, tmo_fire, cache_hit;

  function automatic logic [cnt_width_g-1:0] sat_inc(input logic [cnt_width_g-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign aw_hs   = awvld_q && waddr_channel.ready;
  assign w_hs    = wvld_q && wdata_channel.ready;
  assign b_hs    = brdy_q && wresp_channel.valid;
  assign expired = (tmo_cnt_q == TLAST);
  // A handshake on the expiry edge takes precedence over the abort.
  assign tmo_fire = expired && ((state_q == ADDR && !aw_hs) ||
                                (state_q == DATA && !w_hs)  ||
                                (state_q == RESP && !b_hs));

`ifdef DEC_AXI_MASTER_ADDR_CACHE_EN
  localparam logic [data_width_g-1:0] ADDR_MASK = ~data_width_g'(7);

  logic                    cache_vld_q;
  logic [data_width_g-1:0] cache_addr_q;

  // Out-of-range addresses leave the target's address register untouched, so they must not be cached.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_vld_q <= 1'b0;
    end else if (tmo_fire || (b_hs && wresp_channel.information == 2'b11)) begin
      cache_vld_q <= 1'b0;
    end else if (aw_hs) begin
      cache_vld_q  <= ((awinfo_q & ADDR_MASK) == '0);
      cache_addr_q <= awinfo_q;
    end
  end

  assign cache_hit = cache_vld_q && (cmd_addr == cache_addr_q);
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      awvld_q       <= 1'b0;
      awinfo_q      <= '0;
      wvld_q        <= 1'b0;
      winfo_q       <= '0;
      brdy_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_code_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
      okay_cnt_q    <= '0;
      err_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      tmo_cnt_q   <= tmo_cnt_q + 1'b1;
      if (tmo_fire) begin
        state_q       <= IDLE;
        awvld_q       <= 1'b0;
        awinfo_q      <= '0;
        wvld_q        <= 1'b0;
        winfo_q       <= '0;
        brdy_q        <= 1'b0;
        rsp_valid_q   <= 1'b1;
        rsp_timeout_q <= 1'b1;
        rsp_code_q    <= 2'b10;
        err_cnt_q     <= sat_inc(err_cnt_q);
      end else begin
        case (state_q)
          IDLE: begin
            tmo_cnt_q <= '0;
            // cmd_ready comes up one cycle after completion or reset release.
            if (!cmd_ready_q) begin
              cmd_ready_q <= 1'b1;
            end else if (cmd_valid) begin
              cmd_ready_q <= 1'b0;
              data_q      <= cmd_data;
              if (cache_hit) begin
                state_q <= DATA;
                wvld_q  <= 1'b1;
                winfo_q <= cmd_data;
              end else begin
                state_q  <= ADDR;
                awvld_q  <= 1'b1;
                awinfo_q <= cmd_addr;
              end
            end
          end
          ADDR: if (aw_hs) begin
            awvld_q   <= 1'b0;
            awinfo_q  <= '0;
            wvld_q    <= 1'b1;
            winfo_q   <= data_q;
            tmo_cnt_q <= '0;
            state_q   <= DATA;
          end
          DATA: if (w_hs) begin
            wvld_q    <= 1'b0;
            winfo_q   <= '0;
            brdy_q    <= 1'b1;
            tmo_cnt_q <= '0;
            state_q   <= RESP;
          end
          RESP: if (b_hs) begin
            brdy_q        <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_code_q    <= wresp_channel.information;
            rsp_timeout_q <= 1'b0;
            if (wresp_channel.information == 2'b00) okay_cnt_q <= sat_inc(okay_cnt_q);
            else                                    err_cnt_q  <= sat_inc(err_cnt_q);
            state_q       <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign cmd_ready                 = cmd_ready_q;
  assign waddr_channel.valid       = awvld_q;
  assign waddr_channel.information = awinfo_q;
  assign wdata_channel.valid       = wvld_q;
  assign wdata_channel.information = winfo_q;
  assign wresp_channel.ready       = brdy_q;
  assign rsp_valid                 = rsp_valid_q;
  assign rsp_code                  = rsp_code_q;
  assign rsp_timeout               = rsp_timeout_q;
  assign okay_count                = okay_cnt_q;
  assign err_count                 = err_cnt_q;
endmodule

// File: tb/tb_decrypter_axi_master.sv
// Bench for decrypter_axi_master: reactive AXI-Lite target model plus a response scoreboard.
module tb_decrypter_axi_master;
  localparam logic [31:0] KEY_ADDR  = 32'h0000_0000;
  localparam logic [31:0] DATA_ADDR = 32'h0000_0004;
  localparam int          CNT_W     = 6;
`ifdef DEC_AXI_MASTER_ADDR_CACHE_EN
  localparam int EXP_AW  = 2;
  localparam int HIT_LAT = 3;
`else
  localparam int EXP_AW  = 21;
  localparam int HIT_LAT = 4;
`endif

  typedef struct packed { logic [1:0] code; logic tmo; } exp_t;

  logic             clk, rst, cmd_valid, cmd_ready, rsp_valid, rsp_timeout;
  logic [31:0]      cmd_addr, cmd_data;
  logic [1:0]       rsp_code;
  logic [CNT_W-1:0] okay_count, err_count;

  axi_channel #(.width_g(32)) waddr_if ();
  axi_channel #(.width_g(32)) wdata_if ();
  axi_channel #(.width_g(2))  wresp_if ();

  decrypter_axi_master #(.data_width_g(32), .timeout_g(8), .cnt_width_g(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .waddr_channel(waddr_if), .wdata_channel(wdata_if), .wresp_channel(wresp_if),
    .rsp_valid(rsp_valid), .rsp_code(rsp_code), .rsp_timeout(rsp_timeout),
    .okay_count(okay_count), .err_count(err_count)
  );

  exp_t        exp_q[$];
  int          n_vec = 0, n_err = 0, n_rsp = 0, n_aw = 0;
  int          wk = 0, w_wait = 0;
  bit          aw_en = 1'b1, b_en = 1'b1, tgt_key = 1'b0, tgt_bad = 1'b0;
  logic [31:0] last_aw = '0, last_w = '0, tgt_addr = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Target: range 0..7, DATA before KEY -> SLVERR, out-of-range address -> DECERR (old address kept).
  always @(negedge clk) begin
    if (rst) begin
      tgt_key = 1'b0; tgt_bad = 1'b0; tgt_addr = '0; wk = 0;
      waddr_if.ready = 1'b0; wdata_if.ready = 1'b0;
      wresp_if.valid = 1'b0; wresp_if.information = 2'b00;
    end else begin
      waddr_if.ready = aw_en;
      if (waddr_if.valid === 1'b1 && aw_en) begin
        n_aw++;
        last_aw = waddr_if.information;
        if (waddr_if.information <= 32'h7) begin
          tgt_addr = waddr_if.information;
          tgt_bad  = 1'b0;
        end else begin
          tgt_bad = 1'b1;
        end
      end
      if (wdata_if.valid === 1'b1) wk++; else wk = 0;
      wdata_if.ready = (wk > w_wait);
      if (wdata_if.valid === 1'b1 && wdata_if.ready) begin
        last_w = wdata_if.information;
        if (tgt_bad)                                wresp_if.information = 2'b11;
        else if (tgt_addr == DATA_ADDR && !tgt_key) wresp_if.information = 2'b10;
        else                                        wresp_if.information = 2'b00;
        if (!tgt_bad && tgt_addr == KEY_ADDR) tgt_key = 1'b1;
      end
      wresp_if.valid = b_en;
    end
  end

  // Scoreboard: every rsp_valid pulse consumes one expected response.
  always @(negedge clk) begin
    if (!rst && rsp_valid === 1'b1) begin
      exp_t e;
      n_rsp++;
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_code", rsp_code, e.code);
        chk("rsp_timeout", rsp_timeout, e.tmo);
      end
    end
  end

  task automatic start(input logic [31:0] a, input logic [31:0] d, input logic [1:0] code, input logic tmo);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d;
    exp_q.push_back({code, tmo});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat, output int nw);
    lat = 1; nw = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      if (wdata_if.valid === 1'b1) nw++;
      @(posedge clk); #1; lat++;
    end
    if (rsp_valid !== 1'b1) chk("rsp_wait", rsp_valid, 1'b1);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] code, output int lat);
    int nw;
    start(a, d, code, 1'b0);
    wait_rsp(lat, nw);
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 1'b0; w_wait = 0; b_en = 1'b1;
    repeat (2) @(posedge clk); #1;
    exp_q.delete();
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got %0d vectors", n_vec);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, nw, aw0, snap;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_awvalid", waddr_if.valid, 1'b0);
    chk("rst_awinfo", waddr_if.information, 32'h0);
    chk("rst_wvalid", wdata_if.valid, 1'b0);
    chk("rst_winfo", wdata_if.information, 32'h0);
    chk("rst_bready", wresp_if.ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_code", rsp_code, 2'b00);
    chk("rst_rsp_tmo", rsp_timeout, 1'b0);
    chk("rst_okay", okay_count, 0);
    chk("rst_err", err_count, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rdy_after_rst", cmd_ready, 1'b1);

    // Key write, full-handshake latency
    send(KEY_ADDR, 32'hA5A5_0001, 2'b00, lat);
    chk("key_lat", lat, 4);
    chk("key_okay", okay_count, 1);
    chk("rdy_in_rsp", cmd_ready, 1'b0);
    chk("key_aw", last_aw, KEY_ADDR);
    chk("key_w", last_w, 32'hA5A5_0001);
    @(posedge clk); #1;
    chk("rsp_one_cycle", rsp_valid, 1'b0);
    chk("rdy_after_rsp", cmd_ready, 1'b1);
    chk("awinfo_zeroed", waddr_if.information, 32'h0);

    // Data before key
    do_reset();
    send(DATA_ADDR, 32'h0000_0011, 2'b10, lat);
    @(posedge clk); #1;
    chk("slverr_code_hold", rsp_code, 2'b10);
    chk("slverr_tmo", rsp_timeout, 1'b0);
    chk("slverr_err", err_count, 1);
    chk("slverr_okay", okay_count, 0);

    // Key then 20 back-to-back data writes
    do_reset();
    aw0 = n_aw;
    send(KEY_ADDR, 32'h0BAD_CAFE, 2'b00, lat);
    for (int i = 0; i < 20; i++) begin
      send(DATA_ADDR, 32'h1000 + i, 2'b00, lat);
      if (i == 1) chk("hit_lat", lat, HIT_LAT);
    end
    chk("burst_aw_count", n_aw - aw0, EXP_AW);
    chk("burst_okay", okay_count, 21);
    chk("burst_last_w", last_w, 32'h1000 + 19);

    // DECERR invalidates the cache
    aw0 = n_aw;
    send(DATA_ADDR + 166, 32'h2222, 2'b11, lat);
    chk("decerr_err", err_count, 1);
    send(DATA_ADDR, 32'h3333, 2'b00, lat);
    chk("decerr_aw_rerun", n_aw - aw0, 2);
    chk("decerr_next_lat", lat, 4);
    chk("decerr_okay", okay_count, 22);

    // Handshake on the expiry edge wins, then a real timeout
    do_reset();
    w_wait = 7;
    send(KEY_ADDR, 32'h4444, 2'b00, lat);
    chk("expiry_hs_lat", lat, 11);
    chk("expiry_hs_tmo", rsp_timeout, 1'b0);
    w_wait = 1000;
    start(KEY_ADDR, 32'h5555, 2'b10, 1'b1);
    wait_rsp(lat, nw);
    chk("tmo_data_cycles", nw, 8);
    chk("tmo_wvalid_low", wdata_if.valid, 1'b0);
    chk("tmo_flag", rsp_timeout, 1'b1);
    chk("tmo_err", err_count, 1);
    w_wait = 0;
    aw0 = n_aw;
    send(KEY_ADDR, 32'h6666, 2'b00, lat);
    chk("tmo_aw_rerun", n_aw - aw0, 1);
    chk("tmo_next_lat", lat, 4);
    chk("tmo_okay", okay_count, 2);

    // Reset during RESP
    do_reset();
    send(KEY_ADDR, 32'h7777, 2'b00, lat);
    chk("pre_rst_okay", okay_count, 1);
    b_en = 1'b0;
    start(DATA_ADDR, 32'h8888, 2'b00, 1'b0);
    nw = 0;
    while (wresp_if.ready !== 1'b1 && nw < 20) begin @(posedge clk); #1; nw++; end
    chk("resp_reached", wresp_if.ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_bready", wresp_if.ready, 1'b0);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst_cmd_ready", cmd_ready, 1'b0);
    chk("mid_rst_okay", okay_count, 0);
    chk("mid_rst_err", err_count, 0);
    chk("mid_rst_code", rsp_code, 2'b00);
    exp_q.delete();
    snap = n_rsp;
    rst = 1'b0; b_en = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_rdy_rise", cmd_ready, 1'b1);
    repeat (3) @(posedge clk); #1;
    chk("mid_rst_no_rsp", n_rsp, snap);

    // err_count saturation
    do_reset();
    for (int i = 0; i < 70; i++) begin
      send(DATA_ADDR, i, 2'b10, lat);
      if (i == 62) chk("err_at_63", err_count, 63);
    end
    chk("err_saturated", err_count, 63);
    chk("sat_okay", okay_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
